fft_agu_param: RTL and testbench
================================

FFT_AGU_PARAM -- requirements
Module: fft_agu_param

Interface
REQ-001 LOG2N, default 10, log2 of FFT length N (N = 2^LOG2N, legal 3..12).
REQ-002 GAP_CYC, default 4, idle cycles between stages for butterfly pipeline drain (legal 1..15).
REQ-003 Reset rst_n, synchronous, active-low; clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 start_i  in  1  request new transform; sampled only in IDLE.
REQ-007 en_i  in  1  advance enable; low = stall.
REQ-008 inv_i  in  1  inverse-transform select; sampled with start_i.
REQ-009 addr_a_o  out  LOG2N  butterfly upper-input address.
REQ-010 addr_b_o  out  LOG2N  butterfly lower-input address.
REQ-011 tw_addr_o  out  LOG2N-1  twiddle ROM address.
REQ-012 tw_conj_o  out  1  conjugate twiddle (latched inv_i).
REQ-013 memsel_o  out  1  ping-pong bank select = stage LSB.
REQ-014 stage_o  out  4  current stage index s.
REQ-015 valid_o  out  1  address/twiddle outputs valid this cycle.
REQ-016 busy_o  out  1  high from start acceptance until DONE exit.
REQ-017 done_o  out  1  one-cycle pulse after the last butterfly of the last stage.

Function
REQ-018 FSM states IDLE, GEN, GAP, DONE; IDLE->GEN on start_i; GEN->GAP at j=N/2-1 with en_i and s<LOG2N-1; GEN->DONE at j=N/2-1 with en_i and s=LOG2N-1; GAP->GEN after GAP_CYC enabled cycles, s+1, j=0; DONE->IDLE unconditionally.
REQ-019 Butterfly counter j (LOG2N-1 bits) increments in GEN only when en_i=1; stage counter s increments only on GAP exit.
REQ-020 addr_a_o = ROTL_LOG2N({j,0}, s); addr_b_o = ROTL_LOG2N({j,1}, s).
REQ-021 tw_addr_o = (j << (LOG2N-1-s)) truncated to LOG2N-1 bits.
REQ-022 All outputs registered: values for (s,j) appear one cycle after the GEN cycle computing them; first valid_o two cycles after start_i sampled.
REQ-023 valid_o = 1 only for enabled GEN cycles (delayed per REQ-022); stalled, GAP, DONE and IDLE cycles give valid_o=0, addresses/tw_addr 0.
REQ-024 memsel_o, stage_o, tw_conj_o hold through GAP and stalls.
REQ-025 GAP counter advances only when en_i=1.
REQ-026 start_i outside IDLE (including DONE) ignored; inv_i latched only at acceptance.
REQ-027 Exactly LOG2N*N/2 valid cycles per transform; no j wrap-around without stage change.
REQ-028 done_o asserted exactly in cycle after the last valid_o... registered from DONE state, one cycle wide.

Reset
REQ-029 rst_n=0 at any time, including mid-transform: next state IDLE, j=s=gap=0, all outputs 0 next edge; no done_o emitted for aborted transform.
REQ-030 Reset dominates start_i in the same cycle.

Structure
REQ-031 Package fft_agu_pkg holds state encoding, LOG2N legality limits and the ROTL width helper.
REQ-032 One sub-module fft_addr_rotl (combinational LOG2N-bit insert-and-rotate of j, b, s), instantiated twice (b=0, b=1).

Verification (LOG2N=3, GAP_CYC=2 unless noted)
REQ-033 start_i pulse, en_i=1 -> stage0 pairs (0,1)(2,3)(4,5)(6,7); stage1 (0,2)(4,6)(1,3)(5,7); stage2 (0,4)(1,5)(2,6)(3,7); tw stage0 0,0,0,0; stage1 0,2,0,2; stage2 0,1,2,3.
REQ-034 Same run -> 12 valid cycles, 2-cycle gaps with valid_o=0, memsel_o 0/1/0, done_o single pulse, busy_o low after DONE.
REQ-035 en_i low 3 cycles mid-stage1 at j=2 -> outputs frozen-invalid, resume at (1,3) with no skipped/duplicated pair.
REQ-036 rst_n low at stage1 j=1 -> all outputs 0 next cycle, IDLE, no done_o; fresh start_i restarts at stage0 j=0.
REQ-037 start_i held high through whole run with inv_i=1 -> single transform, tw_conj_o=1 throughout, new transform begins only after return to IDLE.
REQ-038 LOG2N=10 default -> 5120 valid cycles, stage9 addr_a_o=j, addr_b_o=512+j.

Source files
------------

// File: rtl/fft_agu_pkg.sv
// Shared definitions for the FFT address generator: FSM encoding, legal
// transform sizes and the variable-width rotate used for butterfly addressing.
package fft_agu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } agu_state_t;

  localparam int unsigned LOG2N_MIN = 3;
  localparam int unsigned LOG2N_MAX = 12;

  // Rotate the low w bits of v left by sh (sh < w); bits above w come back 0.
  function automatic logic [LOG2N_MAX-1:0] rotl(input logic [LOG2N_MAX-1:0] v,
                                                input logic [3:0]           sh,
                                                input logic [3:0]           w);
    logic [LOG2N_MAX-1:0] r;
    logic [4:0]           idx;
    r = '0;
    for (int i = 0; i < LOG2N_MAX; i++) begin
      idx = 5'(i) + {1'b0, sh};
      if (idx >= {1'b0, w}) idx = idx - {1'b0, w};
      if (5'(i) < {1'b0, w}) r[idx[3:0]] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_rotl.sv
// Builds a butterfly address: insert bit b below counter j, then rotate the
// LOG2N-bit result left by the stage index s. Purely combinational.
module fft_addr_rotl
  import fft_agu_pkg::*;
#(
  parameter int LOG2N = 10
) (
  input  logic [LOG2N-2:0] j,
  input  logic             b,
  input  logic [3:0]       s,
  output logic [LOG2N-1:0] addr
);

  assign addr = LOG2N'(rotl(LOG2N_MAX'({j, b}), s, 4'(LOG2N)));

endmodule

// File: rtl/fft_agu_param.sv
// Radix-2 in-place FFT address generator: walks LOG2N stages of N/2 butterflies,
// emitting registered operand/twiddle addresses with a drain gap between stages.
module fft_agu_param
  import fft_agu_pkg::*;
#(
  parameter int LOG2N   = 10,
  parameter int GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             inv_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             tw_conj_o,
  output logic             memsel_o,
  output logic [3:0]       stage_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int JW = LOG2N - 1;

  if (LOG2N < int'(LOG2N_MIN) || LOG2N > int'(LOG2N_MAX) || GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_param
    $error("fft_agu_param: LOG2N or GAP_CYC out of range");
  end

  agu_state_t       state;
  logic [JW-1:0]    j;
  logic [3:0]       s;
  logic [3:0]       gap;
  logic             inv_q;

  logic [LOG2N-1:0] addr_a_c;
  logic [LOG2N-1:0] addr_b_c;
  logic [JW-1:0]    tw_c;
  logic [3:0]       tw_sh;

  fft_addr_rotl #(.LOG2N(LOG2N)) u_rotl_a (.j(j), .b(1'b0), .s(s), .addr(addr_a_c));
  fft_addr_rotl #(.LOG2N(LOG2N)) u_rotl_b (.j(j), .b(1'b1), .s(s), .addr(addr_b_c));

  // Twiddle stride halves each stage; bits shifted past JW are dropped.
  assign tw_sh = 4'(LOG2N - 1) - s;
  assign tw_c  = j << tw_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      j         <= '0;
      s         <= '0;
      gap       <= '0;
      inv_q     <= 1'b0;
      addr_a_o  <= '0;
      addr_b_o  <= '0;
      tw_addr_o <= '0;
      tw_conj_o <= 1'b0;
      memsel_o  <= 1'b0;
      stage_o   <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      addr_a_o  <= '0;
      addr_b_o  <= '0;
      tw_addr_o <= '0;
      done_o    <= 1'b0;
      stage_o   <= s;
      memsel_o  <= s[0];
      tw_conj_o <= inv_q;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_GEN;
            j      <= '0;
            s      <= '0;
            gap    <= '0;
            inv_q  <= inv_i;
            busy_o <= 1'b1;
          end
        end
        ST_GEN: begin
          if (en_i) begin
            valid_o   <= 1'b1;
            addr_a_o  <= addr_a_c;
            addr_b_o  <= addr_b_c;
            tw_addr_o <= tw_c;
            if (&j) begin
              j   <= '0;
              gap <= '0;
              state <= (s == 4'(LOG2N - 1)) ? ST_DONE : ST_GAP;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (en_i) begin
            if (gap == 4'(GAP_CYC - 1)) begin
              gap   <= '0;
              s     <= s + 4'd1;
              state <= ST_GEN;
            end else begin
              gap <= gap + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_agu_param.sv
// Bench for fft_agu_param: small (LOG2N=3) instance against a butterfly-order
// model, plus a default-size instance for the full-length count and last stage.
module tb_fft_agu_param;

  localparam int L = 3;
  localparam int G = 2;
  localparam int N = 1 << L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, en_i = 1'b0, inv_i = 1'b0;
  logic [2:0] addr_a_o, addr_b_o;
  logic [1:0] tw_addr_o;
  logic       tw_conj_o, memsel_o, valid_o, busy_o, done_o;
  logic [3:0] stage_o;

  logic       start2 = 1'b0, en2 = 1'b0, inv2 = 1'b0;
  logic [9:0] addr_a2, addr_b2;
  logic [8:0] tw_addr2;
  logic       tw_conj2, memsel2, valid2, busy2, done2;
  logic [3:0] stage2;

  fft_agu_param #(.LOG2N(L), .GAP_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .en_i(en_i), .inv_i(inv_i),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .tw_addr_o(tw_addr_o),
    .tw_conj_o(tw_conj_o), .memsel_o(memsel_o), .stage_o(stage_o),
    .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o));

  fft_agu_param dut_big (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .en_i(en2), .inv_i(inv2),
    .addr_a_o(addr_a2), .addr_b_o(addr_b2), .tw_addr_o(tw_addr2),
    .tw_conj_o(tw_conj2), .memsel_o(memsel2), .stage_o(stage2),
    .valid_o(valid2), .busy_o(busy2), .done_o(done2));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {int a; int b; int tw; int s;} bf_t;
  bf_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rotl_ref(int x, int sh, int w);
    return ((x << sh) | (x >> (w - sh))) & ((1 << w) - 1);
  endfunction

  // Expected butterfly sequence: stage-major, j-minor.
  task automatic build_q();
    bf_t e;
    q.delete();
    for (int st = 0; st < L; st++)
      for (int jj = 0; jj < N / 2; jj++) begin
        e.a  = rotl_ref(2 * jj, st, L);
        e.b  = rotl_ref(2 * jj + 1, st, L);
        e.tw = (jj << (L - 1 - st)) & ((N / 2) - 1);
        e.s  = st;
        q.push_back(e);
      end
  endtask

  // mode 0: en always 1; 1: random en; 2: 3-cycle stall at stage1 j=2; 3: en 1, abort via reset
  task automatic run(input int mode, input bit inv, input bit hold, input int abort_at);
    int nval, inval_run, prev_s, stall_left;
    bit exp_done, got_done, stall_seen;
    bf_t e;
    build_q();
    @(negedge clk);
    start_i = 1'b1; inv_i = inv; en_i = 1'b1;
    nval = 0; inval_run = 0; prev_s = -1; stall_left = 0;
    exp_done = 0; got_done = 0; stall_seen = 0;
    for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      inv_i = 1'($urandom_range(0, 1));
      check("done_timing", done_o, exp_done);
      if (exp_done) begin
        got_done = 1;
        check("busy_after_done", busy_o, 0);
      end else begin
        check("busy_during_run", busy_o, 1);
      end
      if (valid_o) begin
        check("valid_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("addr_a", addr_a_o, e.a);
          check("addr_b", addr_b_o, e.b);
          check("tw_addr", tw_addr_o, e.tw);
          check("stage", stage_o, e.s);
          check("memsel", memsel_o, e.s & 1);
          check("tw_conj", tw_conj_o, inv);
          if (mode == 0) begin
            if (nval == 0) check("first_latency", cyc, 2);
            else if (e.s != prev_s) check("gap_len", inval_run, G);
            else check("no_bubble", inval_run, 0);
          end
          if (mode == 2 && nval == 6) check("stall_len", inval_run, 3);
          prev_s = e.s;
          nval++;
          inval_run = 0;
          if (q.size() == 0) exp_done = 1;
        end
      end else begin
        check("invalid_zero", {addr_a_o, addr_b_o, tw_addr_o}, 0);
        if (nval > 0 && q.size() > 0) begin
          check("hold_stage", stage_o, prev_s);
          check("hold_memsel", memsel_o, prev_s & 1);
          check("hold_conj", tw_conj_o, inv);
        end
        inval_run++;
      end
      if (abort_at > 0 && nval == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      case (mode)
        1: en_i = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0) begin
            en_i = 1'b0; stall_left--;
          end else if (!stall_seen && nval == 6 && valid_o) begin
            en_i = 1'b0; stall_left = 2; stall_seen = 1;
          end else begin
            en_i = 1'b1;
          end
        end
        default: en_i = 1'b1;
      endcase
    end
    check("done_seen", got_done, 1);
    check("all_pairs_issued", q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {addr_a_o, addr_b_o, tw_addr_o, tw_conj_o, memsel_o, stage_o,
                valid_o, busy_o, done_o}, 0);
  endtask

  initial begin
    int nv, jc;
    bit seen_done;

    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    check("reset_state_big", {valid2, busy2, done2, stage2, addr_a2}, 0);
    rst_n = 1'b1;

    run(0, 1'b0, 1'b0, 0);
    run(2, 1'b1, 1'b0, 0);

    run(3, 1'b0, 1'b0, 5);
    @(negedge clk);
    check_all_zero("abort_outputs");
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", {done_o, busy_o, valid_o}, 0);
    end
    run(0, 1'b1, 1'b0, 0);

    repeat (3) run(1, 1'($urandom_range(0, 1)), 1'b0, 0);

    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b1;
    @(negedge clk);
    check("reset_beats_start", {busy_o, valid_o}, 0);
    rst_n = 1'b1; start_i = 1'b0;
    @(negedge clk);

    run(0, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("restart_after_idle", busy_o, 1);
    check("restart_not_valid_yet", valid_o, 0);
    start_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("hold_cleanup");
    rst_n = 1'b1;

    @(negedge clk);
    start2 = 1'b1; en2 = 1'b1;
    nv = 0; jc = 0; seen_done = 0;
    for (int cyc = 0; cyc < 6000 && !seen_done; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (valid2) begin
        nv++;
        if (stage2 == 4'd9) begin
          check("big_s9_addr_a", addr_a2, jc);
          check("big_s9_addr_b", addr_b2, 512 + jc);
          jc++;
        end
      end
      if (done2) seen_done = 1;
    end
    check("big_done_seen", seen_done, 1);
    check("big_valid_count", nv, 5120);
    check("big_s9_count", jc, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
